icache_fetch_ctrl: RTL and testbench

//  Fetch sequencer in front of the compressed-aware icache. Turns redirects from the pipeline

---
 rtl/icache_fetch_ctrl_pkg.sv | 14 +
 rtl/icache_fetch_ctrl_if.sv | 12 +
 rtl/icache_fetch_fifo.sv | 41 ++++
 rtl/icache_fetch_ctrl.sv | 97 +++++++++
 tb/tb_icache_fetch_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/icache_fetch_ctrl_pkg.sv
// icache_fetch_ctrl_pkg: shared types for the fetch sequencer and its output FIFO
package icache_fetch_ctrl_pkg;
  localparam int unsigned XLEN = 64;
  typedef enum logic [2:0] {IF_PREFETCH, IF_MISPREDICT, IF_PROT_CHANGED, IF_SATP_CHANGED, IF_FENCE_I} if_reason_e;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            exception;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc, input logic [31:0] instr);
    return pc + ((instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));
  endfunction
endpackage

// File: rtl/icache_fetch_ctrl_if.sv
// icache_fetch_ctrl_if: request/response bus between the fetch sequencer and the icache
interface icache_fetch_ctrl_if import icache_fetch_ctrl_pkg::*; ;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  if_reason_e      req_reason;
  logic            resp_valid;
  logic [XLEN-1:0] resp_pc;
  logic [31:0]     resp_instr;
  logic            resp_exception;
  modport master(output req_valid, req_pc, req_reason, input resp_valid, resp_pc, resp_instr, resp_exception);
  modport slave(input req_valid, req_pc, req_reason, output resp_valid, resp_pc, resp_instr, resp_exception);
endinterface

// File: rtl/icache_fetch_fifo.sv
// icache_fetch_fifo: small circular buffer of fetched instructions with synchronous flush
module icache_fetch_fifo import icache_fetch_ctrl_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_pop, do_push;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign head = mem[rd];
  assign do_pop = pop && valid;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  always_ff @(posedge clk)
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (do_push) mem[wr] <= din;
endmodule

// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: turns redirects into icache requests, prefetches sequentially, buffers responses for decode
module icache_fetch_ctrl import icache_fetch_ctrl_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  if_reason_e        redirect_reason,
  icache_fetch_ctrl_if.master icache,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr_pc,
  output logic [31:0]       instr_word,
  output logic              instr_exception,
  output logic              busy
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  fetch_state_e state, state_n;
  logic outstanding, outstanding_n, pending, pending_n;
  logic [XLEN-1:0] pend_pc, next_pc, req_pc;
  if_reason_e pend_reason, req_reason;
  logic req_valid, resp_ok, push, pop, space;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign resp_ok = icache.resp_valid && outstanding;
  assign pop = instr_ready && instr_valid;
  assign space = (count - CW'(pop)) < CW'(DEPTH);
  // pending doubles as the stale mark on the outstanding request
  assign push = resp_ok && !pending && !redirect_valid;
  always_comb begin
    state_n = state;
    outstanding_n = outstanding;
    pending_n = pending;
    req_valid = 1'b0;
    req_pc = {redirect_pc[XLEN-1:1], 1'b0};
    req_reason = redirect_reason;
    if (redirect_valid) begin
      state_n = RUN;
      if (!outstanding || icache.resp_valid) begin
        req_valid = 1'b1;
        outstanding_n = 1'b1;
        pending_n = 1'b0;
      end else pending_n = 1'b1;
    end else if (resp_ok && pending) begin
      req_valid = 1'b1;
      req_pc = pend_pc;
      req_reason = pend_reason;
      pending_n = 1'b0;
    end else if (resp_ok) begin
      outstanding_n = 1'b0;
      state_n = icache.resp_exception ? HALT : state;
    end else if (state == RUN && !outstanding && space) begin
      req_valid = 1'b1;
      req_pc = next_pc;
      req_reason = IF_PREFETCH;
      outstanding_n = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      outstanding <= 1'b0;
      pending <= 1'b0;
      pend_pc <= '0;
      pend_reason <= IF_PREFETCH;
      next_pc <= '0;
    end else begin
      state <= state_n;
      outstanding <= outstanding_n;
      pending <= pending_n;
      if (redirect_valid) begin
        pend_pc <= {redirect_pc[XLEN-1:1], 1'b0};
        pend_reason <= redirect_reason;
      end
      if (push) next_pc <= seq_pc(icache.resp_pc, icache.resp_instr);
    end
  icache_fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .din('{pc: icache.resp_pc, instr: icache.resp_instr, exception: icache.resp_exception}),
    .pop(pop),
    .head(head),
    .valid(instr_valid),
    .count(count)
  );
  assign icache.req_valid = req_valid;
  assign icache.req_pc = req_pc;
  assign icache.req_reason = req_reason;
  assign instr_pc = head.pc;
  assign instr_word = head.instr;
  assign instr_exception = head.exception;
  assign busy = outstanding || pending;
  a_resp_expected: assert property (@(posedge clk) disable iff (rst) icache.resp_valid |-> outstanding);
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: directed scenarios then random traffic against a queue-based fetch model
module tb_icache_fetch_ctrl;
  import icache_fetch_ctrl_pkg::*;
  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  logic clk = 1'b0;
  logic rst;
  logic redirect_valid, instr_valid, instr_ready, instr_exception, busy;
  logic [63:0] redirect_pc, instr_pc;
  logic [31:0] instr_word;
  if_reason_e redirect_reason;
  icache_fetch_ctrl_if icache();
  icache_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_reason(redirect_reason), .icache(icache), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_pc(instr_pc), .instr_word(instr_word),
    .instr_exception(instr_exception), .busy(busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int mode = M_IDLE;
  bit m_out = 0, m_pend = 0;
  logic [63:0] m_pend_pc = '0, m_next_pc = '0, em_pc = '0;
  if_reason_e m_pend_r = IF_PREFETCH;
  fetch_entry_t q[$];
  logic obs_v;
  logic [63:0] obs_pc;
  if_reason_e obs_r;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock: drive inputs, check the combinational request, advance the model, check registered outputs
  task automatic step(input bit rv, input logic [63:0] rpc, input if_reason_e rr, input bit rdy,
                      input bit rsp_req, input logic [31:0] ins, input bit exc);
    bit rsp, popped, e_v;
    logic [63:0] e_pc, len;
    logic [31:0] word;
    if_reason_e e_r;
    fetch_entry_t ent;
    rsp = rsp_req && m_out;
    word = (ins[1:0] == 2'b11) ? ins : {16'h0, ins[15:0]};
    redirect_valid = rv;
    redirect_pc = rpc;
    redirect_reason = rr;
    instr_ready = rdy;
    icache.resp_valid = rsp;
    icache.resp_pc = em_pc;
    icache.resp_instr = word;
    icache.resp_exception = exc;
    popped = rdy && q.size() > 0;
    e_v = 0;
    e_pc = rpc & ~64'h1;
    e_r = rr;
    if (rv) e_v = !m_out || rsp;
    else if (rsp && m_pend) begin
      e_v = 1;
      e_pc = m_pend_pc;
      e_r = m_pend_r;
    end else if (!rsp && mode == M_RUN && !m_out && (q.size() - int'(popped)) < DEPTH) begin
      e_v = 1;
      e_pc = m_next_pc;
      e_r = IF_PREFETCH;
    end
    #1;
    obs_v = icache.req_valid;
    obs_pc = icache.req_pc;
    obs_r = icache.req_reason;
    check("req_valid", 64'(obs_v), 64'(e_v));
    if (e_v) begin
      check("req_pc", obs_pc, e_pc);
      check("req_reason", 64'(obs_r), 64'(e_r));
    end
    if (popped) void'(q.pop_front());
    if (rv) begin
      q.delete();
      mode = M_RUN;
      if (e_v) begin
        m_out = 1;
        m_pend = 0;
        em_pc = e_pc;
      end else begin
        m_pend = 1;
        m_pend_pc = e_pc;
        m_pend_r = rr;
      end
    end else if (rsp && m_pend) begin
      m_pend = 0;
      em_pc = e_pc;
    end else if (rsp) begin
      ent.pc = em_pc;
      ent.instr = word;
      ent.exception = exc;
      q.push_back(ent);
      len = (word[1:0] == 2'b11) ? 64'd4 : 64'd2;
      m_next_pc = em_pc + len;
      m_out = 0;
      if (exc) mode = M_HALT;
    end else if (e_v) begin
      m_out = 1;
      em_pc = e_pc;
    end
    @(posedge clk);
    #1;
    check("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr_pc", instr_pc, q[0].pc);
      check("instr_word", 64'(instr_word), 64'(q[0].instr));
      check("instr_exc", 64'(instr_exception), 64'(q[0].exception));
    end
    check("busy", 64'(busy), 64'(m_out || m_pend));
  endtask
  initial begin
    bit rv;
    logic [63:0] pc;
    rst = 1;
    redirect_valid = 0;
    redirect_pc = '0;
    redirect_reason = IF_PREFETCH;
    instr_ready = 0;
    icache.resp_valid = 0;
    icache.resp_pc = '0;
    icache.resp_instr = '0;
    icache.resp_exception = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 64'(icache.req_valid), 0);
    check("rst_instr_valid", 64'(instr_valid), 0);
    check("rst_busy", 64'(busy), 0);
    rst = 0;
    step(1, 64'h1000, IF_MISPREDICT, 1, 0, 0, 0);
    check("t1_pc", obs_pc, 64'h1000);
    check("t1_reason", 64'(obs_r), 64'(IF_MISPREDICT));
    step(0, 0, IF_PREFETCH, 1, 1, 32'h0000_0013, 0);
    step(0, 0, IF_PREFETCH, 1, 0, 0, 0);
    check("t1_seq32", obs_pc, 64'h1004);
    step(0, 0, IF_PREFETCH, 1, 1, 32'h0000_4501, 0);
    step(0, 0, IF_PREFETCH, 1, 0, 0, 0);
    check("t1_seq16", obs_pc, 64'h1006);
    check("t1_reason_pf", 64'(obs_r), 64'(IF_PREFETCH));
    for (int i = 0; i < 6; i++) step(0, 0, IF_PREFETCH, 0, 1, 32'h0000_0013, 0);
    step(0, 0, IF_PREFETCH, 0, 0, 0, 0);
    check("t2_full_no_req", 64'(obs_v), 0);
    check("t2_full_valid", 64'(instr_valid), 1);
    step(0, 0, IF_PREFETCH, 1, 0, 0, 0);
    check("t2_pop_req", 64'(obs_v), 1);
    step(1, 64'h2000, IF_MISPREDICT, 1, 0, 0, 0);
    check("t3_busy", 64'(busy), 1);
    check("t3_no_req", 64'(obs_v), 0);
    step(0, 0, IF_PREFETCH, 1, 1, 32'h0000_0013, 0);
    check("t3_pend_pc", obs_pc, 64'h2000);
    check("t3_not_pushed", 64'(instr_valid), 0);
    step(0, 0, IF_PREFETCH, 0, 1, 32'h0000_0013, 0);
    step(0, 0, IF_PREFETCH, 0, 0, 0, 0);
    step(1, 64'h2469, IF_FENCE_I, 1, 1, 32'h0000_0013, 0);
    check("t4_pc", obs_pc, 64'h2468);
    check("t4_flushed", 64'(instr_valid), 0);
    step(1, 64'h3000, IF_MISPREDICT, 0, 1, 32'h0000_0013, 0);
    step(0, 0, IF_PREFETCH, 0, 1, 32'h0000_0013, 1);
    check("t5_exc", 64'(instr_exception), 1);
    check("t5_exc_pc", instr_pc, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, IF_PREFETCH, 1, 0, 0, 0);
      check("t5_halt", 64'(obs_v), 0);
    end
    step(1, 64'h4000, IF_MISPREDICT, 1, 0, 0, 0);
    check("t5_restart", obs_pc, 64'h4000);
    step(0, 0, IF_PREFETCH, 1, 1, 32'h0000_0001, 0);
    step(1, 64'hFFFF_FFFF_FFFF_FFFE, IF_MISPREDICT, 1, 0, 0, 0);
    step(0, 0, IF_PREFETCH, 1, 1, 32'h0000_0001, 0);
    step(0, 0, IF_PREFETCH, 1, 0, 0, 0);
    check("t6_wrap", obs_pc, 64'h0);
    for (int n = 0; n < 3000; n++) begin
      rv = $urandom_range(0, 11) == 0;
      pc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))) : {32'h0, $urandom()};
      step(rv, pc, if_reason_e'(3'($urandom_range(0, 4))), $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 15) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
